// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - AHB-Lite encodings and pipeline stage types for ibex_ahbl_master
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Address-phase slot; addr already carries the byte offset decoded from be.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic        valid;
  } stage_a_t;

  typedef struct packed {
    logic        write;
    logic [31:0] wdata;
    logic        valid;
  } stage_d_t;

endpackage

// File: rtl/ibex_ahbl_master_if.sv
// rtl/ibex_ahbl_master_if.sv - AHB-Lite master bus bundle
// HRESP is present only when AHBL_MASTER_HRESP_EN is defined.
interface ibex_ahbl_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
`ifdef AHBL_MASTER_HRESP_EN
  logic        HRESP;

  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  input  HREADY, HRDATA, HRESP);
  modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  output HREADY, HRDATA, HRESP);
`else
  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  input  HREADY, HRDATA);
  modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  output HREADY, HRDATA);
`endif
endinterface

// File: rtl/ahbl_be_decode.sv
// rtl/ahbl_be_decode.sv - byte-enable to HSIZE / address offset decoder
// Illegal patterns decode as a word at offset 0 so they can still be issued.
module ahbl_be_decode
  import ahbl_pkg::*;
(
  input  logic [3:0] be_i,
  output logic [2:0] size_o,
  output logic [1:0] off_o,
  output logic       illegal_o
);

  always_comb begin
    size_o    = HSIZE_WORD;
    off_o     = 2'd0;
    illegal_o = 1'b0;
    case (be_i)
      4'b0001: begin size_o = HSIZE_BYTE; off_o = 2'd0; end
      4'b0010: begin size_o = HSIZE_BYTE; off_o = 2'd1; end
      4'b0100: begin size_o = HSIZE_BYTE; off_o = 2'd2; end
      4'b1000: begin size_o = HSIZE_BYTE; off_o = 2'd3; end
      4'b0011: begin size_o = HSIZE_HALF; off_o = 2'd0; end
      4'b1100: begin size_o = HSIZE_HALF; off_o = 2'd2; end
      4'b1111: begin size_o = HSIZE_WORD; off_o = 2'd0; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ibex_ahbl_master.sv
// rtl/ibex_ahbl_master.sv - Ibex req/gnt/rvalid port to AHB-Lite master, two-stage pipeline
// Optional error response handling: define AHBL_MASTER_HRESP_EN.
module ibex_ahbl_master
  import ahbl_pkg::*;
#(
  parameter bit BE_CHECK = 1'b1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  ibex_ahbl_master_if.master        ahb
);

  stage_a_t    a_q, a_d;
  stage_d_t    d_q, d_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  dec_size;
  logic [1:0]  dec_off;
  logic        dec_illegal;
  logic        local_err;
  logic        a_free;
  logic        gnt;
  logic        bus_err;
  logic        htrans_cancel;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  ahbl_be_decode u_be_decode (
    .be_i      (be_i),
    .size_o    (dec_size),
    .off_o     (dec_off),
    .illegal_o (dec_illegal)
  );

`ifdef AHBL_MASTER_HRESP_EN
  assign bus_err       = ahb.HRESP;
  assign htrans_cancel = ahb.HRESP && !ahb.HREADY;
`else
  assign bus_err       = 1'b0;
  assign htrans_cancel = 1'b0;
`endif

  assign local_err = BE_CHECK && dec_illegal;
  assign a_free    = !a_q.valid || ahb.HREADY;
  // A locally answered request must wait for an empty pipeline to keep responses in order.
  assign gnt       = req_i && !HRESET &&
                     (local_err ? (!a_q.valid && !d_q.valid) : a_free);

  always_comb begin
    a_d = a_q;
    if (a_free) begin
      a_d.valid = 1'b0;
      if (gnt && !local_err) begin
        a_d.addr  = {addr_i[31:2], dec_off};
        a_d.size  = dec_size;
        a_d.write = we_i;
        a_d.wdata = wdata_i;
        a_d.valid = 1'b1;
      end
    end

    d_d = d_q;
    if (ahb.HREADY) begin
      d_d.valid = a_q.valid;
      if (a_q.valid) begin
        d_d.write = a_q.write;
        d_d.wdata = a_q.wdata;
      end
    end

    rvalid_d = 1'b0;
    rdata_d  = 32'd0;
    err_d    = 1'b0;
    if (ahb.HREADY && d_q.valid) begin
      rvalid_d = 1'b1;
      err_d    = bus_err;
      rdata_d  = (d_q.write || bus_err) ? 32'd0 : ahb.HRDATA;
    end else if (gnt && local_err) begin
      rvalid_d = 1'b1;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_q      <= '0;
      d_q      <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      d_q      <= d_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o      = gnt;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;

  assign ahb.HADDR  = a_q.addr;
  assign ahb.HTRANS = (a_q.valid && !htrans_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HWRITE = a_q.write;
  assign ahb.HSIZE  = a_q.size;
  assign ahb.HWDATA = d_q.wdata;

endmodule
